// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signals of the UART receiver
interface uart_rx_if;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       receiving;
  logic       framing_error;

  modport master (
    output serial_in,
    input  data_out,
    input  data_valid,
    input  receiving,
    input  framing_error
  );

  modport slave (
    input  serial_in,
    output data_out,
    output data_valid,
    output receiving,
    output framing_error
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling, single-cycle valid/framing-error pulses
module uart_rx #(
  parameter int unsigned CLOCKS_PER_BIT = 217
) (
  input  logic     clock,
  input  logic     reset,
  uart_rx_if.slave rx_if
);

  localparam logic [15:0] BIT_LAST  = 16'(CLOCKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLOCKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t      state_q;
  logic        sync1_q;
  logic        rx_sync_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        data_valid_q;
  logic        framing_error_q;

  logic [15:0] cnt_d;
  logic [7:0]  shift_d;

  always_comb begin
    cnt_d              = cnt_q + 16'd1;
    shift_d            = shift_q;
    shift_d[bit_idx_q] = rx_sync_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      sync1_q         <= 1'b1;
      rx_sync_q       <= 1'b1;
      cnt_q           <= 16'd0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      data_q          <= 8'h00;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      sync1_q         <= rx_if.serial_in;
      rx_sync_q       <= sync1_q;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q     <= 16'd0;
          bit_idx_q <= 3'd0;
          if (!rx_sync_q) state_q <= START_BIT;
        end
        START_BIT: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= 16'd0;
            // a line that is high again at mid-start was only a glitch
            state_q <= rx_sync_q ? IDLE : DATA_BITS;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DATA_BITS: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= 16'd0;
            shift_q <= shift_d;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= 3'd0;
              state_q   <= STOP_BIT;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        STOP_BIT: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= 16'd0;
            // leaving at mid-stop leaves half a bit to catch a back-to-back start edge
            if (rx_sync_q) begin
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              framing_error_q <= 1'b1;
              state_q         <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_HIGH: begin
          if (rx_sync_q) state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= 16'd0;
          bit_idx_q <= 3'd0;
        end
      endcase
    end
  end

  assign rx_if.data_out      = data_q;
  assign rx_if.data_valid    = data_valid_q;
  assign rx_if.framing_error = framing_error_q;
  assign rx_if.receiving     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 16 and 217 clocks per bit
module tb_uart_rx;

  localparam int CPB_A = 16;
  localparam int CPB_B = 217;

  logic clock;
  logic reset;
  uart_rx_if ifa ();
  uart_rx_if ifb ();

  uart_rx #(.CLOCKS_PER_BIT(CPB_A)) dut_a (.clock(clock), .reset(reset), .rx_if(ifa.slave));
  uart_rx #(.CLOCKS_PER_BIT(CPB_B)) dut_b (.clock(clock), .reset(reset), .rx_if(ifb.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int dv_a_cnt = 0;
  int fe_a_cnt = 0;
  int dv_a_last = 0;
  int dv_a_prev = 0;
  int dv_b_cyc = 0;
  int done_cyc = 0;
  logic dv_a_d = 1'b0;
  logic fe_a_d = 1'b0;
  logic tx_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (ifa.data_valid) begin
      dv_a_cnt++;
      dv_a_prev = dv_a_last;
      dv_a_last = cyc;
      check("a_dv_width", {31'd0, dv_a_d}, 32'd0);
      check("a_dv_fe_excl", {31'd0, ifa.framing_error}, 32'd0);
      if (qa.size() == 0) check("a_dv_unexpected", 32'd1, 32'd0);
      else check("a_data", {24'd0, ifa.data_out}, {24'd0, qa.pop_front()});
    end
    if (ifa.framing_error) begin
      fe_a_cnt++;
      check("a_fe_width", {31'd0, fe_a_d}, 32'd0);
    end
    dv_a_d = ifa.data_valid;
    fe_a_d = ifa.framing_error;
    if (ifb.data_valid) begin
      dv_b_cyc = cyc;
      if (qb.size() == 0) check("b_dv_unexpected", 32'd1, 32'd0);
      else check("b_data", {24'd0, ifb.data_out}, {24'd0, qb.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) ifb.serial_in = v;
    else ifa.serial_in = v;
    tick(n);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop);
    int cpb;
    cpb = sel ? CPB_B : CPB_A;
    drive(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(sel, b[i], cpb);
    drive(sel, stop, cpb);
  endtask

  initial begin
    int dv0;
    int fe0;
    logic [7:0] ab;
    reset = 1'b0;
    ifa.serial_in = 1'b1;
    ifb.serial_in = 1'b1;
    tick(3);
    check("rst_data_out", {24'd0, ifa.data_out}, 32'h00);
    check("rst_data_valid", {31'd0, ifa.data_valid}, 32'd0);
    check("rst_receiving", {31'd0, ifa.receiving}, 32'd0);
    check("rst_framing_error", {31'd0, ifa.framing_error}, 32'd0);
    reset = 1'b1;
    tick(5);

    // single clean frame
    dv0 = dv_a_cnt; fe0 = fe_a_cnt;
    qa.push_back(8'h55);
    send_frame(1'b0, 8'h55, 1'b1);
    tick(8);
    check("f55_dv_count", dv_a_cnt - dv0, 32'd1);
    check("f55_fe_count", fe_a_cnt - fe0, 32'd0);
    check("f55_receiving", {31'd0, ifa.receiving}, 32'd0);
    check("f55_data_out", {24'd0, ifa.data_out}, 32'h55);

    // 4-cycle glitch on the line
    dv0 = dv_a_cnt; fe0 = fe_a_cnt;
    drive(1'b0, 1'b0, 4);
    check("glitch_receiving_hi", {31'd0, ifa.receiving}, 32'd1);
    drive(1'b0, 1'b1, 8);
    check("glitch_receiving_lo", {31'd0, ifa.receiving}, 32'd0);
    check("glitch_dv", dv_a_cnt - dv0, 32'd0);
    check("glitch_fe", fe_a_cnt - fe0, 32'd0);
    tick(16);

    // good byte, then bad stop bit followed by a long break
    qa.push_back(8'h3C);
    send_frame(1'b0, 8'h3C, 1'b1);
    tick(8);
    dv0 = dv_a_cnt; fe0 = fe_a_cnt;
    send_frame(1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 40 * CPB_A);
    check("break_fe_count", fe_a_cnt - fe0, 32'd1);
    check("break_dv_count", dv_a_cnt - dv0, 32'd0);
    check("break_data_out", {24'd0, ifa.data_out}, 32'h3C);
    check("break_receiving", {31'd0, ifa.receiving}, 32'd1);
    drive(1'b0, 1'b1, 4);
    check("break_recover", {31'd0, ifa.receiving}, 32'd0);
    tick(16);

    // back-to-back frames with no idle gap
    dv0 = dv_a_cnt;
    qa.push_back(8'h01);
    qa.push_back(8'h80);
    send_frame(1'b0, 8'h01, 1'b1);
    send_frame(1'b0, 8'h80, 1'b1);
    tick(8);
    check("b2b_dv_count", dv_a_cnt - dv0, 32'd2);
    check("b2b_spacing", dv_a_last - dv_a_prev, 32'd160);
    tick(16);

    // reset during data bit 4, then a fresh frame
    ab = 8'h5A;
    dv0 = dv_a_cnt;
    drive(1'b0, 1'b0, CPB_A);
    for (int i = 0; i < 4; i++) drive(1'b0, ab[i], CPB_A);
    drive(1'b0, ab[4], CPB_A / 2);
    reset = 1'b0;
    ifa.serial_in = 1'b1;
    tick(2);
    check("mid_rst_data_out", {24'd0, ifa.data_out}, 32'h00);
    check("mid_rst_data_valid", {31'd0, ifa.data_valid}, 32'd0);
    check("mid_rst_receiving", {31'd0, ifa.receiving}, 32'd0);
    check("mid_rst_framing_error", {31'd0, ifa.framing_error}, 32'd0);
    tick(3);
    reset = 1'b1;
    tick(8 * CPB_A);
    check("abort_no_pulse", dv_a_cnt - dv0, 32'd0);
    qa.push_back(8'hC3);
    send_frame(1'b0, 8'hC3, 1'b1);
    tick(8);
    check("after_rst_data_out", {24'd0, ifa.data_out}, 32'hC3);
    check("after_rst_dv_count", dv_a_cnt - dv0, 32'd1);

    // loopback at full bit time against a behavioural transmitter
    qb.push_back(8'hA5);
    send_frame(1'b1, 8'hA5, 1'b1);
    tx_done = 1'b1;
    done_cyc = cyc;
    tick(1);
    tx_done = 1'b0;
    tick(10);
    check("loop_data_out", {24'd0, ifb.data_out}, 32'hA5);
    check("loop_dv_seen", {31'd0, (dv_b_cyc != 0)}, 32'd1);
    check("loop_dv_before_done", {31'd0, (dv_b_cyc < done_cyc)}, 32'd1);

    check("sb_a_empty", qa.size(), 32'd0);
    check("sb_b_empty", qb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: UART_RX

Interface
REQ-001 SHALL have parameter: CLOCKS_PER_BIT, default 217, clock cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: serial_in  input  1  asynchronous UART line; idle high, 8N1, LSB first.
REQ-005 SHALL have port: data_out  output  8  last correctly framed byte received.
REQ-006 SHALL have port: data_valid  output  1  one-cycle pulse; data_out is new in the same cycle.
REQ-007 SHALL have port: receiving  output  1  high whenever the FSM is not in IDLE.
REQ-008 SHALL have port: framing_error  output  1  one-cycle pulse when the sampled stop bit is 0.

Function
REQ-009 SHALL pass serial_in through a 2-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-010 SHALL use a 16-bit clock counter, a 3-bit bit index and an 8-bit shift register.
REQ-011 SHALL implement states IDLE, START_BIT, DATA_BITS, STOP_BIT, WAIT_HIGH; any illegal state SHALL go to IDLE next cycle.
REQ-012 IDLE: counter=0, bit index=0; on rx_sync==0 SHALL go to START_BIT.
REQ-013 START_BIT: counter increments until it equals (CLOCKS_PER_BIT-1)/2 (integer division), then samples rx_sync.
REQ-014 At the START_BIT sample: rx_sync==0 -> counter=0, go to DATA_BITS; rx_sync==1 -> treat as glitch, go to IDLE, no output pulse.
REQ-015 DATA_BITS: counter increments until it equals CLOCKS_PER_BIT-1. It then stores rx_sync into shift bit[bit index], clears the counter and increments the bit index. After bit 7 it clears the bit index and goes to STOP_BIT.
REQ-016 Data bit k SHALL be sampled exactly (k+1)*CLOCKS_PER_BIT cycles after the START_BIT sample cycle; the stop bit SHALL be sampled at 9*CLOCKS_PER_BIT.
REQ-017 STOP_BIT sample, rx_sync==1: data_out <= shift register and data_valid=1 on the next cycle; go to IDLE.
REQ-018 STOP_BIT sample, rx_sync==0: framing_error=1 on the next cycle; data_out unchanged; data_valid stays 0; go to WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rx_sync==1, then go to IDLE. A held-low break SHALL NOT produce further frames.
REQ-020 data_valid and framing_error SHALL default to 0 every cycle; they are never high together and never high for more than one cycle per frame.
REQ-021 Back-to-back frames with no idle gap (a new start edge directly after the stop bit) SHALL each be received. The return to IDLE at mid-stop SHALL permit this.
REQ-022 data_out SHALL hold its value between data_valid pulses.
REQ-023 Function SHALL be independent of any upstream handshake. No back-pressure exists; a consumer that misses data_valid loses the byte.

Reset
REQ-024 While reset==0: state=IDLE, counter=0, bit index=0, shift register=0, both synchronizer flops=1.
REQ-025 While reset==0: data_out=8'h00, data_valid=0, receiving=0, framing_error=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no pulse. After release, the first falling edge of rx_sync SHALL start a fresh frame.

Verification
REQ-027 CLOCKS_PER_BIT=16, drive frame 0x55 -> data_out=8'h55, data_valid high exactly 1 cycle, framing_error=0, receiving low after.
REQ-028 CLOCKS_PER_BIT=16, pulse serial_in low for 4 cycles -> no data_valid, no framing_error, FSM back in IDLE (receiving=0) within 12 cycles.
REQ-029 CLOCKS_PER_BIT=16, after receiving 0x3C, send 0x00 with stop bit=0 and hold low for 40 bit times -> single framing_error pulse, data_out stays 8'h3C, receiving stays 1 until line high.
REQ-030 CLOCKS_PER_BIT=16, frames 0x01 then 0x80 with no idle gap -> two data_valid pulses 160 cycles apart, data 8'h01 then 8'h80.
REQ-031 CLOCKS_PER_BIT=16, assert reset during data bit 4 of a frame, release, then send 0xC3 -> all outputs at reset values during reset, no pulse for the aborted frame, data_out=8'hC3 afterwards.
REQ-032 Loopback with the team's UART_TX transmitter, CLOCKS_PER_BIT=217, send 0xA5 -> data_out=8'hA5, data_valid pulse arrives before that transmitter's transmission_done pulse.
